// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed 3-digit decimal display: segment codes,
// anode patterns and the digit index type.
package seven_segment_pkg;

    typedef logic [1:0] digit_idx_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_DIG0 = 4'b1110;
    localparam logic [3:0] AN_DIG1 = 4'b1101;
    localparam logic [3:0] AN_DIG2 = 4'b1011;
    localparam logic [3:0] AN_DIG3 = 4'b0111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    function automatic logic [3:0] an_code(input digit_idx_t idx);
        case (idx)
            2'd0:    return AN_DIG0;
            2'd1:    return AN_DIG1;
            2'd2:    return AN_DIG2;
            default: return AN_DIG3;
        endcase
    endfunction

endpackage

// File: rtl/seven_segment_seg7_decoder.sv
// BCD digit to active-low seven-segment code; non-decimal codes and the
// blank flag both produce an unlit digit.
module seg7_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seven_segment.sv
// Shows an 8-bit switch value in decimal on a 4-digit multiplexed display,
// with leading-zero blanking and a fixed dwell of SCAN_DIV cycles per digit.
module seven_segment_top
    import seven_segment_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [7:0]       sw_q;
    logic [19:0]      bcd_sh;
    logic [3:0]       ones;
    logic [3:0]       tens;
    logic [3:0]       hundreds;
    logic [CNT_W-1:0] scan_cnt;
    digit_idx_t       idx;
    logic [3:0]       sel_digit;
    logic             sel_blank;
    logic [6:0]       seg_next;

    // Stage 1: input register
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q <= '0;
        end else begin
            sw_q <= sw;
        end
    end

    // Double-dabble: the three BCD nibbles sit above the binary byte
    always_comb begin
        bcd_sh = {12'd0, sw_q};
        for (int i = 0; i < 8; i++) begin
            if (bcd_sh[11:8] >= 4'd5)  bcd_sh[11:8]  = bcd_sh[11:8]  + 4'd3;
            if (bcd_sh[15:12] >= 4'd5) bcd_sh[15:12] = bcd_sh[15:12] + 4'd3;
            if (bcd_sh[19:16] >= 4'd5) bcd_sh[19:16] = bcd_sh[19:16] + 4'd3;
            bcd_sh = bcd_sh << 1;
        end
        ones     = bcd_sh[11:8];
        tens     = bcd_sh[15:12];
        hundreds = bcd_sh[19:16];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit index 3 has no content and is always dark
    always_comb begin
        sel_digit = 4'd0;
        sel_blank = 1'b1;
        case (idx)
            2'd0: begin
                sel_digit = ones;
                sel_blank = 1'b0;
            end
            2'd1: begin
                sel_digit = tens;
                sel_blank = (sw_q < 8'd10);
            end
            2'd2: begin
                sel_digit = hundreds;
                sel_blank = (sw_q < 8'd100);
            end
            default: begin
                sel_digit = 4'd0;
                sel_blank = 1'b1;
            end
        endcase
    end

    seg7_decoder u_dec (
        .digit (sel_digit),
        .blank (sel_blank),
        .seg   (seg_next)
    );

    // Stage 2: segments and anodes registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= AN_OFF;
        end else begin
            seg <= seg_next;
            an  <= an_code(idx);
        end
    end

endmodule

// File: tb/tb_seven_segment_top.sv
// Bench for seven_segment_top with SCAN_DIV=4: a decimal-arithmetic model
// checked every cycle, plus hand-computed directed expectations.
module tb_seven_segment_top;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    logic [6:0] code_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0] wrap_an  [5]  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    logic [6:0] wrap_seg [5]  = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    logic [7:0] cap [4];

    always #5 clk = ~clk;

    seven_segment_top #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw),
        .seg (seg),
        .an  (an)
    );

    function automatic logic [6:0] model_seg(input int v, input int di);
        case (di)
            0:       return code_tab[v % 10];
            1:       return (v < 10)  ? 7'h7F : code_tab[(v / 10) % 10];
            2:       return (v < 100) ? 7'h7F : code_tab[v / 100];
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: display position follows from edges counted since reset release
    int         m_edges = 0;
    int         m_swq   = 0;
    bit         m_valid = 1'b0;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    always @(posedge clk) begin
        int di;
        if (rst) begin
            m_swq   = 0;
            m_edges = 0;
            m_an    = 4'hF;
            m_seg   = 7'h7F;
            m_valid = 1'b1;
        end else if (m_valid) begin
            di      = (m_edges / SCAN_DIV) % 4;
            m_an    = ~(4'b0001 << di);
            m_seg   = model_seg(m_swq, di);
            m_edges = m_edges + 1;
            m_swq   = int'(sw);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_an", {4'h0, an}, {4'h0, m_an});
            check("model_seg", {1'b0, seg}, {1'b0, m_seg});
        end
    end

    task automatic capture(input int v);
        sw = 8'(v);
        repeat (2) step();
        for (int i = 0; i < 4; i++) cap[i] = 8'hFF;
        repeat (16) begin
            step();
            case (an)
                4'hE:    cap[0] = {1'b0, seg};
                4'hD:    cap[1] = {1'b0, seg};
                4'hB:    cap[2] = {1'b0, seg};
                4'h7:    cap[3] = {1'b0, seg};
                default: ;
            endcase
        end
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        sw  = 8'd0;
        repeat (3) step();
        check("reset_an", {4'h0, an}, 8'h0F);
        check("reset_seg", {1'b0, seg}, 8'h7F);

        rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < ((g == 4) ? 1 : 4); c++) begin
                step();
                check("wrap_an", {4'h0, an}, {4'h0, wrap_an[g]});
                check("wrap_seg", {1'b0, seg}, {1'b0, wrap_seg[g]});
            end
        end

        capture(42);
        check("sw42_idx0", cap[0], 8'h24);
        check("sw42_idx1", cap[1], 8'h19);
        check("sw42_idx2", cap[2], 8'h7F);
        check("sw42_idx3", cap[3], 8'h7F);
        capture(255);
        check("sw255_idx0", cap[0], 8'h12);
        check("sw255_idx1", cap[1], 8'h12);
        check("sw255_idx2", cap[2], 8'h24);
        capture(100);
        check("sw100_idx0", cap[0], 8'h40);
        check("sw100_idx1", cap[1], 8'h40);
        check("sw100_idx2", cap[2], 8'h79);
        capture(7);
        check("sw7_idx0", cap[0], 8'h78);
        check("sw7_idx1", cap[1], 8'h7F);

        for (int k = 1; k <= 24; k++) begin
            sw = 8'((k - 1) % 10);
            step();
            if (k >= 2 && an == 4'hE)
                check("step_seg", {1'b0, seg}, {1'b0, code_tab[(k - 2) % 10]});
        end

        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (an == 4'hB) found = 1'b1;
        end
        check("find_idx2", {7'h0, found}, 8'h01);
        rst = 1'b1;
        step();
        check("midrst_an", {4'h0, an}, 8'h0F);
        check("midrst_seg", {1'b0, seg}, 8'h7F);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("restart_an0", {4'h0, an}, 8'h0E);
        end
        step();
        check("restart_an1", {4'h0, an}, 8'h0D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
